// File: rtl/pll_ctrl_pkg.sv
// PLL lock controller shared types and constants.
// State encoding, width helper and reset values.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST       = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RUN       = 3'd2,
    S_FAULT     = 3'd3,
    S_PWD       = 3'd4
  } state_t;

  // Bits needed to encode v distinct values (minimum 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam state_t     RST_STATE    = S_RST;
  localparam logic       RST_PLL_PWD  = 1'b0;
  localparam logic       RST_PLL_RST  = 1'b1;
  localparam logic       RST_RSTODIV  = 1'b1;
  localparam logic       RST_SYS_RST  = 1'b1;
  localparam logic       RST_READY    = 1'b0;
  localparam logic       RST_FAULT    = 1'b0;
  localparam logic [7:0] RST_LOSS_CNT = 8'd0;

endpackage

// File: rtl/pll_lock_ctrl_sync.sv
// Two-flop synchroniser for a single asynchronous bit.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  // Shift the asynchronous bit through two flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL power-down/reset sequencer with lock qualification.
// Owns sys_rst for PLL-clocked logic; retries on timeout.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       clkin1,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       pwd_req,
  input  logic       sw_req,
  output logic       pll_pwd,
  output logic       pll_rst,
  output logic       rstodiv,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] loss_cnt
);

  localparam int MAX_A = (RST_HOLD_CYC > LOCK_STABLE_CYC) ?
                         RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int MAXP  = (MAX_A > LOCK_TIMEOUT_CYC) ?
                         MAX_A : LOCK_TIMEOUT_CYC;
  localparam int CW    = clog2(MAXP + 1);
  localparam int SW    = clog2(LOCK_STABLE_CYC + 1);

  localparam logic [CW-1:0] HOLD_END = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_END   = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STB_END  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]    RETRY_MX = 4'(MAX_RETRY);

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_stable;
  logic [3:0]    r_retry;
  logic          w_lock_s;
  logic          w_restart;
  logic          w_retry_clr;
  logic          w_retry_inc;
  logic          w_loss_inc;
  logic          w_cnt_clr;

  sync_2ff u_sync (
    .i_clk (clkin1),
    .i_rst (rst),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  // Next-state decision in priority order pwd > sw > loss > stable/timeout.
  always_comb begin
    w_nxt       = r_state;
    w_restart   = 1'b0;
    w_retry_clr = 1'b0;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    if (pwd_req) begin
      w_nxt = S_PWD;
    end else if (sw_req && r_state != S_PWD) begin
      w_nxt       = S_RST;
      w_restart   = 1'b1;
      w_retry_clr = 1'b1;
    end else begin
      unique case (r_state)
        S_PWD: w_nxt = S_RST;
        S_RST: begin
          if (r_cnt == HOLD_END) w_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (w_lock_s && r_stable == STB_END) begin
            w_nxt       = S_RUN;
            w_retry_clr = 1'b1;
          end else if (r_cnt == TO_END) begin
            if (r_retry < RETRY_MX) begin
              w_nxt       = S_RST;
              w_retry_inc = 1'b1;
            end else begin
              w_nxt = S_FAULT;
            end
          end
        end
        S_RUN: begin
          if (!w_lock_s) begin
            w_nxt      = S_RST;
            w_loss_inc = 1'b1;
          end
        end
        S_FAULT: w_nxt = S_FAULT;
        default: w_nxt = S_RST;
      endcase
    end
    w_cnt_clr = (w_nxt != r_state) || w_restart;
  end

  // State, counters and outputs decoded from the next state.
  always_ff @(posedge clkin1) begin
    if (rst) begin
      r_state  <= RST_STATE;
      r_cnt    <= '0;
      r_stable <= '0;
      r_retry  <= '0;
      loss_cnt <= RST_LOSS_CNT;
      pll_pwd  <= RST_PLL_PWD;
      pll_rst  <= RST_PLL_RST;
      rstodiv  <= RST_RSTODIV;
      sys_rst  <= RST_SYS_RST;
      ready    <= RST_READY;
      fault    <= RST_FAULT;
    end else begin
      r_state <= w_nxt;
      if (w_cnt_clr) r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      if (w_cnt_clr || !w_lock_s || r_state != S_WAIT_LOCK)
        r_stable <= '0;
      else
        r_stable <= r_stable + 1'b1;
      if (w_retry_clr) r_retry <= '0;
      else if (w_retry_inc) r_retry <= r_retry + 1'b1;
      if (w_loss_inc && loss_cnt != 8'hFF)
        loss_cnt <= loss_cnt + 1'b1;
      unique case (w_nxt)
        S_PWD: begin
          pll_pwd <= 1'b1; pll_rst <= 1'b1; rstodiv <= 1'b1;
          sys_rst <= 1'b1; ready   <= 1'b0; fault   <= 1'b0;
        end
        S_WAIT_LOCK: begin
          pll_pwd <= 1'b0; pll_rst <= 1'b0; rstodiv <= 1'b1;
          sys_rst <= 1'b1; ready   <= 1'b0; fault   <= 1'b0;
        end
        S_RUN: begin
          pll_pwd <= 1'b0; pll_rst <= 1'b0; rstodiv <= 1'b0;
          sys_rst <= 1'b0; ready   <= 1'b1; fault   <= 1'b0;
        end
        S_FAULT: begin
          pll_pwd <= 1'b0; pll_rst <= 1'b1; rstodiv <= 1'b1;
          sys_rst <= 1'b1; ready   <= 1'b0; fault   <= 1'b1;
        end
        default: begin
          pll_pwd <= 1'b0; pll_rst <= 1'b1; rstodiv <= 1'b1;
          sys_rst <= 1'b1; ready   <= 1'b0; fault   <= 1'b0;
        end
      endcase
    end
  end

endmodule
